// File: rtl/hex_pkg.sv
// Shared definitions for the multi-digit hex entry counter: segment font,
// blanking pattern and press-operation encodings.
package hex_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7f;

    typedef enum logic [1:0] {
        MODE_SHIFT = 2'b00,
        MODE_ADD   = 2'b01,
        MODE_SUB   = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    // Active-low font, entry 0 at the least significant slice (bit6=g .. bit0=a).
    localparam logic [15:0][6:0] FONT = {
        7'h0e, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_of(input logic [3:0] nibble);
        return FONT[nibble];
    endfunction

endpackage

// File: rtl/hex_decoder.sv
// Single-digit hex to active-low 7-segment decoder.
module hex_decoder
    import hex_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = seg_of(digit);

endmodule

// File: rtl/key_debounce.sv
// Two-flop synchroniser, stability counter and falling-edge press pulse for
// an active-low push button.
module key_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    logic             sync1_r;
    logic             key_s_r;
    logic             key_stable_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic             press_r;

    // Synchronise, debounce and flag accepted 1->0 transitions of the stable level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r      <= 1'b1;
            key_s_r      <= 1'b1;
            key_stable_r <= 1'b1;
            deb_cnt_r    <= '0;
            press_r      <= 1'b0;
        end else begin
            sync1_r <= key_n;
            key_s_r <= sync1_r;
            press_r <= 1'b0;
            if (key_s_r == key_stable_r) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r == DEB_LAST) begin
                key_stable_r <= key_s_r;
                deb_cnt_r    <= '0;
                press_r      <= ~key_s_r;
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_ONE;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/hex_digits_counter.sv
// N-digit hex entry/counter driven by a debounced key, with registered
// active-low 7-segment outputs that stay blank until the first press.
module hex_digits_counter
    import hex_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int DEB_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_n,
    input  logic [1:0]            mode,
    input  logic [3:0]            switches,
    output logic [4*N_DIGITS-1:0] value,
    output logic                  press,
    output logic [7*N_DIGITS-1:0] hex
);

    localparam int W = 4 * N_DIGITS;

    logic                  press_s;
    logic [W-1:0]          value_r;
    logic                  blank_r;
    logic [7*N_DIGITS-1:0] hex_r;
    logic [7*N_DIGITS-1:0] seg_s;
    logic [W+3:0]          shifted_s;
    logic [W-1:0]          operand_s;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n),
        .press (press_s)
    );

    assign shifted_s = {value_r, switches};
    assign operand_s = W'(switches);

    // Apply the selected operation on each accepted press; reset takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= '0;
            blank_r <= 1'b1;
        end else if (press_s) begin
            blank_r <= 1'b0;
            case (mode_e'(mode))
                MODE_SHIFT: value_r <= shifted_s[W-1:0];
                MODE_ADD:   value_r <= value_r + operand_s;
                MODE_SUB:   value_r <= value_r - operand_s;
                MODE_CLEAR: value_r <= '0;
                default:    value_r <= value_r;
            endcase
        end else begin
            value_r <= value_r;
            blank_r <= blank_r;
        end
    end

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        hex_decoder u_dec (
            .digit (value_r[4*i+3:4*i]),
            .seg   (seg_s[7*i+6:7*i])
        );
    end

    // Display register follows value one edge later, blanked until first press.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_r <= {N_DIGITS{SEG_BLANK}};
        end else if (blank_r) begin
            hex_r <= {N_DIGITS{SEG_BLANK}};
        end else begin
            hex_r <= seg_s;
        end
    end

    assign value = value_r;
    assign press = press_s;
    assign hex   = hex_r;

endmodule

// File: tb/tb_hex_digits_counter.sv
// Self-checking bench for hex_digits_counter with N_DIGITS=4, DEB_CYCLES=4.
module tb_hex_digits_counter;

    logic        clk;
    logic        reset;
    logic        key_n;
    logic [1:0]  mode;
    logic [3:0]  switches;
    logic [15:0] value;
    logic        press;
    logic [27:0] hex;

    int tests;
    int fails;
    logic [15:0] exp_val;
    logic [15:0] sb_q[$];

    hex_digits_counter #(.N_DIGITS(4), .DEB_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n),
        .mode     (mode),
        .switches (switches),
        .value    (value),
        .press    (press),
        .hex      (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'h0: font = 7'h40; 4'h1: font = 7'h79; 4'h2: font = 7'h24; 4'h3: font = 7'h30;
            4'h4: font = 7'h19; 4'h5: font = 7'h12; 4'h6: font = 7'h02; 4'h7: font = 7'h78;
            4'h8: font = 7'h00; 4'h9: font = 7'h10; 4'ha: font = 7'h08; 4'hb: font = 7'h03;
            4'hc: font = 7'h46; 4'hd: font = 7'h21; 4'he: font = 7'h06; default: font = 7'h0e;
        endcase
    endfunction

    function automatic logic [15:0] model(input logic [15:0] v, input logic [1:0] m,
                                          input logic [3:0] sw);
        case (m)
            2'b00:   model = {v[11:0], sw};
            2'b01:   model = v + {12'h000, sw};
            2'b10:   model = v - {12'h000, sw};
            default: model = 16'h0000;
        endcase
    endfunction

    // Hold the key for 'hold' cycles, then release; score value and digit0 after the pulse.
    task automatic press_op(input logic [1:0] m, input logic [3:0] sw, input int hold);
        int pulses;
        logic pend_val, pend_hex;
        logic [15:0] e;
        mode = m; switches = sw; key_n = 1'b0;
        pulses = 0; pend_val = 1'b0; pend_hex = 1'b0;
        for (int i = 0; i < hold + 16; i++) begin
            @(negedge clk);
            if (i == hold) key_n = 1'b1;
            if (pend_hex) begin
                pend_hex = 1'b0;
                tests++;
                if (hex[6:0] !== font(exp_val[3:0])) begin
                    fails++;
                    $display("FAIL digit0 m=%0d sw=%h got %h want %h", m, sw, hex[6:0], font(exp_val[3:0]));
                end
            end
            if (pend_val) begin
                pend_val = 1'b0;
                pend_hex = 1'b1;
                e = sb_q.pop_front();
                tests++;
                if (value !== e) begin
                    fails++;
                    $display("FAIL value m=%0d sw=%h got %h want %h", m, sw, value, e);
                end
                mode = ~m; switches = ~sw;
            end
            if (press === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    exp_val = model(exp_val, m, sw);
                    sb_q.push_back(exp_val);
                    pend_val = 1'b1;
                end
            end
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL pulse_count m=%0d sw=%h got %0d want 1", m, sw, pulses);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; key_n = 1'b1; mode = 2'b00; switches = 4'h0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (value !== 16'h0000 || hex !== {4{7'h7f}} || press !== 1'b0) begin
            fails++;
            $display("FAIL reset_state value=%h hex=%h press=%b want 0000/all 7f/0", value, hex, press);
        end
        reset = 1'b0;
        exp_val = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if (press !== 1'b0 || hex !== {4{7'h7f}}) begin
                fails++;
                $display("FAIL idle press=%b hex=%h want 0/all 7f", press, hex);
            end
        end
    endtask

    task automatic test_glitch();
        int pulses;
        pulses = 0;
        key_n = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 2) key_n = 1'b1;
            if (press === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0 || value !== 16'h0000 || hex !== {4{7'h7f}}) begin
            fails++;
            $display("FAIL glitch pulses=%0d value=%h hex=%h want 0/0000/all 7f", pulses, value, hex);
        end
    endtask

    task automatic test_shift();
        for (int k = 1; k <= 5; k++) press_op(2'b00, 4'(k), 12);
        tests++;
        if (value !== 16'h2345 || hex[27:21] !== 7'h24) begin
            fails++;
            $display("FAIL shift_final value=%h digit3=%h want 2345/24", value, hex[27:21]);
        end
    endtask

    task automatic test_add_sub();
        for (int k = 0; k < 4; k++) press_op(2'b00, 4'hf, 12);
        press_op(2'b01, 4'h1, 12);
        tests++;
        if (value !== 16'h0000) begin
            fails++;
            $display("FAIL add_wrap got %h want 0000", value);
        end
        press_op(2'b10, 4'h2, 12);
        tests++;
        if (value !== 16'hfffe || hex[6:0] !== 7'h06) begin
            fails++;
            $display("FAIL sub_wrap value=%h digit0=%h want fffe/06", value, hex[6:0]);
        end
    endtask

    task automatic test_long_hold_clear();
        press_op(2'b01, 4'h3, 100);
        press_op(2'b11, 4'h9, 12);
        tests++;
        if (value !== 16'h0000 || hex !== {4{7'h40}}) begin
            fails++;
            $display("FAIL clear value=%h hex=%h want 0000/all 40", value, hex);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses;
        bit seen;
        press_op(2'b00, 4'h1, 12);
        press_op(2'b00, 4'h2, 12);
        press_op(2'b00, 4'h3, 12);
        press_op(2'b00, 4'h4, 12);
        mode = 2'b01; switches = 4'h5; key_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (press === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL reset_mid_press got no press want one");
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (value !== 16'h0000 || hex !== {4{7'h7f}}) begin
            fails++;
            $display("FAIL reset_mid value=%h hex=%h want 0000/all 7f", value, hex);
        end
        reset = 1'b0;
        exp_val = 16'h0000;
        sb_q.delete();
        mode = 2'b00; switches = 4'h7;
        n = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (press === 1'b1) begin
                pulses++;
                if (n == 0) n = i;
            end
        end
        tests++;
        if (pulses != 1 || n < 5 || n > 7) begin
            fails++;
            $display("FAIL reset_rearm pulses=%0d at=%0d want 1 at 5..7", pulses, n);
        end
        tests++;
        if (value !== 16'h0007 || hex[6:0] !== 7'h78 || hex[27:7] !== {3{7'h40}}) begin
            fails++;
            $display("FAIL reset_rearm_value value=%h hex=%h want 0007/40404078", value, hex);
        end
        key_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        tests = 0; fails = 0;
        test_reset();
        test_glitch();
        test_shift();
        test_add_sub();
        test_long_hold_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_digits_counter.md
Name: hex_digits_counter

Overview:
- Multi-digit successor of the single-digit switch-to-HEX latch.
- Debounces a raw active-low push button and turns each accepted press into a one-cycle pulse.
- On each press, applies a mode-selected operation (shift-in, add, subtract, clear) to an N-digit hex value.
- Drives N registered 7-segment digits; sits between board keys/switches and the HEX pins.

Parameters:
- N_DIGITS, 4, number of hex digits; value width = 4*N_DIGITS.
- DEB_CYCLES, 50000, consecutive cycles the synchronised key must differ from the stable level before the change is accepted; must be >=2.
- DEB_W, $clog2(DEB_CYCLES+1), width of the debounce counter (derived, not overridden).

Ports:
- clk  in  1  single system clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- key_n  in  1  raw push button, active-low (0 = pressed), asynchronous to clk.
- mode  in  2  operation select, sampled on press pulse.
- switches  in  4  operand nibble, sampled on press pulse.
- value  out  4*N_DIGITS  current counter/entry value.
- press  out  1  one-cycle pulse per accepted press (debug/chaining).
- hex  out  7*N_DIGITS  active-low segments; digit i at bits [7i+6:7i], bit6=g..bit0=a; digit 0 is least significant.

Behaviour:
- Reset values, checked at the first edge with reset=1: sync flops=1, key_stable=1, deb_cnt=0, press=0, value=0, blank=1, every hex digit=7'h7f.
- Synchroniser: two flops on key_n give key_s.
- Debounce:
  - If key_s==key_stable, deb_cnt<=0.
  - Otherwise deb_cnt increments.
  - When deb_cnt==DEB_CYCLES-1 and key_s still differs, key_stable<=key_s and deb_cnt<=0.
  - A glitch shorter than DEB_CYCLES cycles never changes key_stable.
- press: registered, 1 for exactly one cycle after key_stable goes 1->0. Release (0->1) produces no pulse.
- Latency: key_n held low from cycle t gives press high at cycle t+2+DEB_CYCLES (+/-1 for sampling phase). value updates on the next edge; hex updates one edge after value.
- Operation, applied on the edge where press==1, using mode/switches from that cycle:
  - 00 SHIFT: value <= {value[4N-5:0], switches}; the top digit is discarded.
  - 01 ADD: value <= value + switches, modulo 2^(4N); FFFF+1 -> 0000 for N=4.
  - 10 SUB: value <= value - switches, modulo 2^(4N); 0000-1 -> FFFF.
  - 11 CLEAR: value <= 0.
- Blanking: blank clears on the first press after reset, whatever the mode. While blank=1, all digits show 7'h7f.
- Display: hex registered each cycle from value via the per-digit decoder. Leading zeros are shown, not suppressed.
- Font, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset mid-operation: reset wins over press in the same cycle, and all state returns to reset values. A key held low through reset release is debounced afresh and yields one press DEB_CYCLES+2 cycles later.
- mode/switches changing at any time other than the press cycle have no effect.

Decomposition:
- Shared package hex_pkg:
  - SEG_BLANK=7'h7f.
  - Mode encodings MODE_SHIFT/ADD/SUB/CLEAR.
  - 16-entry font constant table.
- Sub-module key_debounce (synchroniser + counter + falling-edge pulse; params DEB_CYCLES).
- The existing decoder is instantiated N_DIGITS times in a generate loop.
- Operation logic and display registers stay in the top.

Test Plan (N_DIGITS=4, DEB_CYCLES=4):
- Reset, then idle 20 cycles -> hex=all 7f, value=0000, press never high.
- key_n low 3 cycles then high -> no press, value=0000, hex still blank.
- Mode 00: press with switches=1,2,3,4,5 -> value 0001, 0012, 0123, 1234, 2345. hex digit0 goes 79, 24, 30, 19, 12; hex digit3=24 at the end. Exactly one press pulse per hold.
- Mode 00 load FFFF, then mode 01 switches=1 -> value 0000. Then mode 10 switches=2 -> value FFFE, digit0=06.
- Press held low 100 cycles -> exactly one press; release -> no press; mode 11 press -> value 0000, hex=40 on all digits.
- reset asserted in the same cycle as press with value=1234 -> value 0000, blank=1, hex all 7f. key still held after reset release -> one press 6+/-1 cycles later.
